// File: rtl/register_bank_writer_if.sv
//==============================================================================
// Module      : register_bank_writer_if
// Description : Processor write-command handshake for the sprite register bank.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface register_bank_writer_if #(
    parameter int SIZE_REG_ADDR = 5,
    parameter int SIZE_DATA     = 32
);
    logic                     cmd_valid;
    logic [SIZE_REG_ADDR-1:0] cmd_reg;
    logic [SIZE_DATA-1:0]     cmd_data;
    logic                     cmd_ready;

    modport master (output cmd_valid, output cmd_reg, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_reg, input cmd_data, output cmd_ready);
endinterface

`default_nettype wire

// File: rtl/register_bank_writer.sv
//==============================================================================
// Module      : register_bank_writer
// Description : Buffers register writes and commits them only between frames.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module register_bank_writer #(
    parameter int SIZE_REG_ADDR  = 5,
    parameter int SIZE_DATA      = 32,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  wire                          clk,
    input  wire                          reset,
    register_bank_writer_if.slave        cmd,
    input  wire                          printtingScreen,
    output logic                         bank_we,
    output logic [SIZE_REG_ADDR-1:0]     bank_addr,
    output logic [SIZE_DATA-1:0]         bank_data,
    output logic [FIFO_ADDR_BITS:0]      pending,
    output logic                         busy
);
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int ENTRY_W = SIZE_REG_ADDR + SIZE_DATA;
    localparam logic [FIFO_ADDR_BITS:0] FULL_COUNT = (FIFO_ADDR_BITS+1)'(DEPTH);
    localparam logic [FIFO_ADDR_BITS:0] ONE_COUNT  = (FIFO_ADDR_BITS+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0]        mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_BITS:0]   count;
    logic                      push, pop;

    // Ready looks only at the occupancy, never at a same-cycle pop.
    assign cmd.cmd_ready = (count != FULL_COUNT);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = (state != S_IDLE) && (count != '0) && !printtingScreen;
    assign pending       = count;
    assign busy          = (count != '0) || bank_we;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd.cmd_reg, cmd.cmd_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            bank_we   <= 1'b0;
            bank_addr <= '0;
            bank_data <= '0;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            bank_we <= pop;
            if (pop) begin
                {bank_addr, bank_data} <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (push) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT, S_COMMIT: begin
                if (pop) begin
                    // Last entry leaving with nothing arriving empties the queue.
                    if ((count == ONE_COUNT) && !push) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_COMMIT;
                    end
                end else begin
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_register_bank_writer.sv
//==============================================================================
// Module      : tb_register_bank_writer
// Description : Directed self-checking bench for register_bank_writer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_register_bank_writer;
    logic        clk;
    logic        reset;
    logic        printtingScreen;
    logic        bank_we;
    logic [4:0]  bank_addr;
    logic [31:0] bank_data;
    logic [2:0]  pending;
    logic        busy;

    int vectors;
    int miscompares;

    logic [36:0] strobe_q[$];

    register_bank_writer_if #(.SIZE_REG_ADDR(5), .SIZE_DATA(32)) cmd_bus ();

    register_bank_writer #(
        .SIZE_REG_ADDR (5),
        .SIZE_DATA     (32),
        .FIFO_ADDR_BITS(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (cmd_bus.slave),
        .printtingScreen(printtingScreen),
        .bank_we        (bank_we),
        .bank_addr      (bank_addr),
        .bank_data      (bank_data),
        .pending        (pending),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && bank_we) strobe_q.push_back({bank_addr, bank_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_blocked(input logic [4:0] r, input logic [31:0] d);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_reg   = r;
        cmd_bus.cmd_data  = d;
        tick();
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (bank_we !== 1'b0 || bank_addr !== 5'd0 || bank_data !== 32'd0) begin
            $display("FAIL reset_bank: we=%b addr=%0d data=%h, want 0/0/0", bank_we, bank_addr, bank_data);
            miscompares++;
        end
        vectors++;
        if (pending !== 3'd0 || busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
            $display("FAIL reset_status: pending=%0d busy=%b ready=%b, want 0/0/1", pending, busy, cmd_bus.cmd_ready);
            miscompares++;
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        printtingScreen   = 1'b0;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_reg   = 5'd3;
        cmd_bus.cmd_data  = 32'hDEADBEEF;
        tick();
        cmd_bus.cmd_valid = 1'b0;
        vectors++;
        if (bank_we !== 1'b0 || pending !== 3'd1) begin
            $display("FAIL single_accept: we=%b pending=%0d, want 0/1", bank_we, pending);
            miscompares++;
        end
        tick();
        vectors++;
        if (bank_we !== 1'b1 || bank_addr !== 5'd3 || bank_data !== 32'hDEADBEEF || pending !== 3'd0 || busy !== 1'b1) begin
            $display("FAIL single_strobe: we=%b addr=%0d data=%h pending=%0d busy=%b, want 1/3/deadbeef/0/1",
                     bank_we, bank_addr, bank_data, pending, busy);
            miscompares++;
        end
        tick();
        vectors++;
        if (bank_we !== 1'b0 || bank_addr !== 5'd3 || bank_data !== 32'hDEADBEEF || busy !== 1'b0) begin
            $display("FAIL single_hold: we=%b addr=%0d data=%h busy=%b, want 0/3/deadbeef/0", bank_we, bank_addr, bank_data, busy);
            miscompares++;
        end
    endtask

    task automatic test_fill_blocked();
        printtingScreen = 1'b1;
        for (int i = 1; i <= 4; i++) push_blocked(5'(i), 32'h11 * i);
        vectors++;
        if (cmd_bus.cmd_ready !== 1'b0 || pending !== 3'd4 || bank_we !== 1'b0) begin
            $display("FAIL fill_full: ready=%b pending=%0d we=%b, want 0/4/0", cmd_bus.cmd_ready, pending, bank_we);
            miscompares++;
        end
        push_blocked(5'd5, 32'h55);
        vectors++;
        if (pending !== 3'd4 || bank_we !== 1'b0) begin
            $display("FAIL fill_refuse: pending=%0d we=%b, want 4/0", pending, bank_we);
            miscompares++;
        end
        printtingScreen = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            vectors++;
            if (bank_we !== 1'b1 || bank_addr !== 5'(i) || bank_data !== 32'h11 * i) begin
                $display("FAIL drain_%0d: we=%b addr=%0d data=%h, want 1/%0d/%h", i, bank_we, bank_addr, bank_data, i, 32'h11 * i);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if (bank_we !== 1'b0 || pending !== 3'd0) begin
            $display("FAIL drain_end: we=%b pending=%0d, want 0/0", bank_we, pending);
            miscompares++;
        end
    endtask

    task automatic test_same_reg();
        printtingScreen = 1'b1;
        strobe_q.delete();
        push_blocked(5'd7, 32'hA);
        push_blocked(5'd7, 32'hB);
        printtingScreen = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if (strobe_q.size() != 2) begin
            $display("FAIL same_reg_count: strobes=%0d, want 2", strobe_q.size());
            miscompares++;
        end else begin
            if (strobe_q[0] !== {5'd7, 32'hA} || strobe_q[1] !== {5'd7, 32'hB}) begin
                $display("FAIL same_reg_order: got %h then %h, want %h then %h",
                         strobe_q[0], strobe_q[1], {5'd7, 32'hA}, {5'd7, 32'hB});
                miscompares++;
            end
        end
        vectors++;
        if (bank_addr !== 5'd7 || bank_data !== 32'hB) begin
            $display("FAIL same_reg_final: addr=%0d data=%h, want 7/b", bank_addr, bank_data);
            miscompares++;
        end
    endtask

    task automatic test_pause();
        printtingScreen = 1'b1;
        for (int i = 0; i < 4; i++) push_blocked(5'(8 + i), 32'h100 + i);
        printtingScreen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (bank_we !== 1'b1 || bank_addr !== 5'(8 + i) || pending !== 3'(3 - i)) begin
                $display("FAIL pause_pre_%0d: we=%b addr=%0d pending=%0d, want 1/%0d/%0d", i, bank_we, bank_addr, pending, 8 + i, 3 - i);
                miscompares++;
            end
        end
        printtingScreen = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (bank_we !== 1'b0 || pending !== 3'd2) begin
                $display("FAIL pause_hold_%0d: we=%b pending=%0d, want 0/2", i, bank_we, pending);
                miscompares++;
            end
        end
        printtingScreen = 1'b0;
        for (int i = 2; i < 4; i++) begin
            tick();
            vectors++;
            if (bank_we !== 1'b1 || bank_addr !== 5'(8 + i) || bank_data !== 32'h100 + i || pending !== 3'(3 - i)) begin
                $display("FAIL pause_post_%0d: we=%b addr=%0d data=%h pending=%0d, want 1/%0d/%h/%0d",
                         i, bank_we, bank_addr, bank_data, pending, 8 + i, 32'h100 + i, 3 - i);
                miscompares++;
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [36:0] exp_q[$];
        int model_cnt;
        int next_id;
        int sent;
        printtingScreen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_blocked(5'(12 + i), 32'hC000 + i);
            exp_q.push_back({5'(12 + i), 32'hC000 + i});
        end
        model_cnt = 4;
        strobe_q.delete();
        printtingScreen = 1'b0;
        next_id = 16;
        sent = 0;
        for (int cyc = 0; cyc < 30 && sent < 6; cyc++) begin
            cmd_bus.cmd_valid = 1'b1;
            cmd_bus.cmd_reg   = 5'(next_id);
            cmd_bus.cmd_data  = 32'hB000 + next_id;
            vectors++;
            if (cmd_bus.cmd_ready !== (model_cnt != 4)) begin
                $display("FAIL b2b_ready_c%0d: ready=%b, want %b", cyc, cmd_bus.cmd_ready, model_cnt != 4);
                miscompares++;
            end
            if (model_cnt != 4) begin
                exp_q.push_back({5'(next_id), 32'hB000 + next_id});
                next_id++;
                sent++;
                model_cnt++;
            end
            if (model_cnt > 0 && !(model_cnt == 5)) model_cnt--;
            else if (model_cnt == 5) model_cnt--;
            tick();
            vectors++;
            if (pending !== 3'(model_cnt)) begin
                $display("FAIL b2b_pending_c%0d: pending=%0d, want %0d", cyc, pending, model_cnt);
                miscompares++;
            end
        end
        cmd_bus.cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (strobe_q.size() != exp_q.size()) begin
            $display("FAIL b2b_count: strobes=%0d, want %0d", strobe_q.size(), exp_q.size());
            miscompares++;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (strobe_q[i] !== exp_q[i]) begin
                    $display("FAIL b2b_entry_%0d: got %h, want %h", i, strobe_q[i], exp_q[i]);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_async_reset();
        printtingScreen = 1'b1;
        for (int i = 0; i < 4; i++) push_blocked(5'(20 + i), 32'hE000 + i);
        printtingScreen = 1'b0;
        tick();
        vectors++;
        if (bank_we !== 1'b1 || pending !== 3'd3) begin
            $display("FAIL areset_pre: we=%b pending=%0d, want 1/3", bank_we, pending);
            miscompares++;
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (bank_we !== 1'b0 || bank_addr !== 5'd0 || bank_data !== 32'd0 || pending !== 3'd0
            || busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
            $display("FAIL areset_now: we=%b addr=%0d data=%h pending=%0d busy=%b ready=%b, want 0/0/0/0/0/1",
                     bank_we, bank_addr, bank_data, pending, busy, cmd_bus.cmd_ready);
            miscompares++;
        end
        tick();
        reset = 1'b1;
        strobe_q.delete();
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (strobe_q.size() != 0 || pending !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL areset_after: strobes=%0d pending=%0d busy=%b, want 0/0/0", strobe_q.size(), pending, busy);
            miscompares++;
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b0;
        printtingScreen   = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_reg   = '0;
        cmd_bus.cmd_data  = '0;
        test_reset();
        test_single();
        test_fill_blocked();
        test_same_reg();
        test_pause();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
